// File: rtl/grid_pkg.sv
// Shared grid geometry, state encoding and toroidal coordinate helpers for
// the Life grid sequencer.
package grid_pkg;

    localparam int GRID_W = 80;
    localparam int GRID_H = 60;
    localparam int X_W    = $clog2(GRID_W);
    localparam int Y_W    = $clog2(GRID_H);

    typedef logic [GRID_W-1:0][GRID_H-1:0] grid_t;
    typedef logic [X_W-1:0]                xcoord_t;
    typedef logic [Y_W-1:0]                ycoord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Edit/clear held off while a generation is in flight
    typedef struct packed {
        logic    clear;
        logic    edit;
        xcoord_t x;
        ycoord_t y;
        logic    val;
    } pend_t;

    localparam xcoord_t X_LAST = xcoord_t'(GRID_W - 1);
    localparam ycoord_t Y_LAST = ycoord_t'(GRID_H - 1);

    function automatic xcoord_t x_inc(input xcoord_t x);
        return (x == X_LAST) ? '0 : xcoord_t'(x + 1'b1);
    endfunction

    function automatic xcoord_t x_dec(input xcoord_t x);
        return (x == '0) ? X_LAST : xcoord_t'(x - 1'b1);
    endfunction

    function automatic ycoord_t y_inc(input ycoord_t y);
        return (y == Y_LAST) ? '0 : ycoord_t'(y + 1'b1);
    endfunction

    function automatic ycoord_t y_dec(input ycoord_t y);
        return (y == '0) ? Y_LAST : ycoord_t'(y - 1'b1);
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 next-state rule for one cell from its centre bit and 8 neighbours.
module life_cell_rule (
    input  logic       centre_i,
    input  logic [7:0] nbr_i,
    output logic       next_o
);

    logic [3:0] cnt;

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'b000, nbr_i[i]};
        end
    end

    assign next_o = (cnt == 4'd3) | (centre_i & (cnt == 4'd2));

endmodule

// File: rtl/life_grid_sequencer.sv
// Owns the displayed Life grid: scans one cell per cycle into a shadow buffer,
// commits a whole generation at once, and serialises edits/clears around it.
module life_grid_sequencer
    import grid_pkg::*;
#(
    parameter int GEN_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic             run,
    input  logic             step_req,
    input  logic             clear_req,
    input  logic             edit_we,
    input  logic [6:0]       edit_x,
    input  logic [5:0]       edit_y,
    input  logic             edit_val,
    output grid_t            LOCAL_REG,
    output logic             busy,
    output logic             missed,
    output logic [GEN_W-1:0] generation
);

    state_e            state_q, state_d;
    xcoord_t           x_q, x_d;
    ycoord_t           y_q, y_d;
    grid_t             grid_q, grid_d;
    grid_t             shadow_q;
    pend_t             pend_q, pend_d;
    logic              frame_q;
    logic              missed_q;
    logic [GEN_W-1:0]  gen_q;

    logic    trig, edit_ok, last_cell;
    logic    scan_en, commit_en, apply_en;
    logic    cell_next;
    logic [7:0] nbr;
    xcoord_t xm, xp;
    ycoord_t ym, yp;

    assign trig      = step_req | (run & frame_clk & ~frame_q);
    assign edit_ok   = edit_we && (edit_x < xcoord_t'(GRID_W)) && (edit_y < ycoord_t'(GRID_H));
    assign last_cell = scan_en && (x_q == X_LAST) && (y_q == Y_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trig) state_d = SCAN;
            SCAN:    if (last_cell) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_en   = 1'b0;
        commit_en = 1'b0;
        apply_en  = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE:    apply_en = 1'b1;
            SCAN:    begin scan_en = 1'b1; busy = 1'b1; end
            COMMIT:  begin commit_en = 1'b1; apply_en = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // ---------------- scan index, y inner / x outer ----------------
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (state_q == IDLE && trig) begin
            x_d = '0;
            y_d = '0;
        end else if (scan_en) begin
            y_d = y_inc(y_q);
            if (y_q == Y_LAST) x_d = x_inc(x_q);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // ---------------- rule evaluation from the displayed grid ----------------
    assign xm = x_dec(x_q);
    assign xp = x_inc(x_q);
    assign ym = y_dec(y_q);
    assign yp = y_inc(y_q);

    assign nbr = {grid_q[xm][ym], grid_q[x_q][ym], grid_q[xp][ym],
                  grid_q[xm][y_q],                  grid_q[xp][y_q],
                  grid_q[xm][yp], grid_q[x_q][yp], grid_q[xp][yp]};

    life_cell_rule u_rule (
        .centre_i (grid_q[x_q][y_q]),
        .nbr_i    (nbr),
        .next_o   (cell_next)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)       shadow_q <= '0;
        else if (scan_en) shadow_q[x_q][y_q] <= cell_next;
    end

    // ---------------- pending edit/clear merge ----------------
    // Folding the current request into pend_d lets IDLE and COMMIT share one
    // apply path, and an edit landing on the COMMIT cycle is not lost.
    always_comb begin
        pend_d = pend_q;
        if (clear_req) begin
            pend_d.clear = 1'b1;
            pend_d.edit  = 1'b0;
        end else if (edit_ok) begin
            pend_d.edit = 1'b1;
            pend_d.x    = edit_x;
            pend_d.y    = edit_y;
            pend_d.val  = edit_val;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)        pend_q <= '0;
        else if (apply_en) pend_q <= '0;
        else               pend_q <= pend_d;
    end

    // ---------------- displayed grid ----------------
    always_comb begin
        grid_d = commit_en ? shadow_q : grid_q;
        if (pend_d.clear) grid_d = '0;
        if (pend_d.edit)  grid_d[pend_d.x][pend_d.y] = pend_d.val;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)        grid_q <= '0;
        else if (apply_en) grid_q <= grid_d;
    end

    // ---------------- edge detect, missed pulse, generation count ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_q  <= 1'b0;
            missed_q <= 1'b0;
            gen_q    <= '0;
        end else begin
            frame_q  <= frame_clk;
            missed_q <= trig && (state_q != IDLE);
            if (commit_en) gen_q <= gen_q + 1'b1;
        end
    end

    assign LOCAL_REG  = grid_q;
    assign missed     = missed_q;
    assign generation = gen_q;

endmodule

// File: tb/tb_life_grid_sequencer.sv
// Directed + randomized bench for life_grid_sequencer against an array-based
// Conway reference model.
module tb_life_grid_sequencer;
    import grid_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        run = 1'b0;
    logic        step_req = 1'b0;
    logic        clear_req = 1'b0;
    logic        edit_we = 1'b0;
    logic [6:0]  edit_x = '0;
    logic [5:0]  edit_y = '0;
    logic        edit_val = 1'b0;
    grid_t       LOCAL_REG;
    logic        busy, missed;
    logic [15:0] generation;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_gen = 0;
    bit mg [GRID_W][GRID_H];

    int gx [5] = '{1, 2, 0, 1, 2};
    int gy [5] = '{0, 1, 2, 2, 2};

    life_grid_sequencer #(.GEN_W(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .run        (run),
        .step_req   (step_req),
        .clear_req  (clear_req),
        .edit_we    (edit_we),
        .edit_x     (edit_x),
        .edit_y     (edit_y),
        .edit_val   (edit_val),
        .LOCAL_REG  (LOCAL_REG),
        .busy       (busy),
        .missed     (missed),
        .generation (generation)
    );

    always #5 Clk = ~Clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic grid_t model_grid();
        grid_t g = '0;
        for (int x = 0; x < GRID_W; x++)
            for (int y = 0; y < GRID_H; y++)
                g[x][y] = mg[x][y];
        return g;
    endfunction

    task automatic model_clear();
        for (int x = 0; x < GRID_W; x++)
            for (int y = 0; y < GRID_H; y++)
                mg[x][y] = 1'b0;
    endtask

    task automatic model_step();
        bit nx [GRID_W][GRID_H];
        int n;
        for (int x = 0; x < GRID_W; x++)
            for (int y = 0; y < GRID_H; y++) begin
                n = 0;
                for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++)
                        if (dx != 0 || dy != 0)
                            n += int'(mg[(x + dx + GRID_W) % GRID_W][(y + dy + GRID_H) % GRID_H]);
                nx[x][y] = (n == 3) || (mg[x][y] && n == 2);
            end
        mg = nx;
        exp_gen = (exp_gen + 1) % 65536;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_grid(input string tag);
        grid_t e;
        int nd, fx, fy;
        e = model_grid();
        n_cmp++;
        assert (LOCAL_REG === e) else begin
            nd = 0; fx = 0; fy = 0;
            for (int x = 0; x < GRID_W; x++)
                for (int y = 0; y < GRID_H; y++)
                    if (LOCAL_REG[x][y] !== e[x][y]) begin
                        if (nd == 0) begin fx = x; fy = y; end
                        nd++;
                    end
            n_fail++;
            $error("FAIL %s: LOCAL_REG wrong in %0d cells, first (%0d,%0d) got %b want %b",
                   tag, nd, fx, fy, LOCAL_REG[fx][fy], e[fx][fy]);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_step();
        step_req = 1'b1;
        cyc(1);
        step_req = 1'b0;
    endtask

    task automatic do_edit(input int x, input int y, input bit v);
        edit_we  = 1'b1;
        edit_x   = 7'(x);
        edit_y   = 6'(y);
        edit_val = v;
        cyc(1);
        edit_we  = 1'b0;
    endtask

    task automatic do_clear(input bit upd_model);
        clear_req = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        if (upd_model) model_clear();
    endtask

    // Random soup via IDLE edits, some deliberately out of range
    task automatic seed_soup(input int n);
        int x, y;
        bit v;
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 85);
            y = $urandom_range(0, 63);
            v = ($urandom_range(0, 2) != 0);
            do_edit(x, y, v);
            if (x < GRID_W && y < GRID_H) mg[x][y] = v;
        end
    endtask

    task automatic wait_idle(input string tag, input int exp_lat);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 6000) begin
            @(negedge Clk);
            cnt++;
        end
        if (exp_lat >= 0) chk(tag, cnt, exp_lat);
        else              chk(tag, (cnt < 6000) ? 1 : 0, 1);
    endtask

    initial begin
        // ---- reset ----
        model_clear();
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk_grid("reset grid");
        chk("reset busy", busy, 0);
        chk("reset missed", missed, 0);
        chk("reset gen", generation, 0);
        Reset = 1'b1;
        cyc(2);

        // ---- blinker ----
        do_edit(10, 5, 1); mg[10][5] = 1;
        chk_grid("idle edit visible next cycle");
        do_edit(10, 6, 1); mg[10][6] = 1;
        do_edit(10, 7, 1); mg[10][7] = 1;
        do_step();
        chk("blinker busy", busy, 1);
        wait_idle("blinker latency", 4801);
        model_step();
        chk_grid("blinker grid");
        chk("blinker (9,6)", LOCAL_REG[9][6], 1);
        chk("blinker (10,5)", LOCAL_REG[10][5], 0);
        chk("blinker gen", generation, 1);
        chk("blinker busy low", busy, 0);

        // ---- glider across the (79,59)/(0,0) corner ----
        do_clear(1'b1);
        chk_grid("clear");
        for (int i = 0; i < 5; i++) begin
            mg[(78 + gx[i]) % GRID_W][(58 + gy[i]) % GRID_H] = 1;
            do_edit((78 + gx[i]) % GRID_W, (58 + gy[i]) % GRID_H, 1);
        end
        for (int g = 0; g < 4; g++) begin
            do_step();
            wait_idle("glider done", -1);
            model_step();
            chk_grid("glider gen");
        end
        model_clear();
        for (int i = 0; i < 5; i++)
            mg[(79 + gx[i]) % GRID_W][(59 + gy[i]) % GRID_H] = 1;
        chk_grid("glider translated +1,+1");
        chk("glider gen count", generation, 16'(exp_gen));

        // ---- random soup ----
        do_clear(1'b1);
        seed_soup(400);
        chk_grid("soup seeded");
        do_step();
        wait_idle("soup done", 4801);
        model_step();
        chk_grid("soup gen");

        // ---- edits during SCAN are deferred to COMMIT; newer overwrites older ----
        do_step();
        cyc(48);
        do_edit(70, 50, 1);
        chk_grid("scan edit held");
        cyc(50);
        do_edit(3, 3, 1);
        chk("scan (3,3) held", LOCAL_REG[3][3], 32'(mg[3][3]));
        wait_idle("scan edit latency", 4701);
        model_step();
        mg[3][3] = 1;
        chk_grid("scan edit after commit");
        chk("scan edit gen", generation, 16'(exp_gen));

        // ---- frame trigger overlap ----
        run = 1'b1;
        frame_clk = 1'b1;
        cyc(1);
        chk("frame trig busy", busy, 1);
        frame_clk = 1'b0;
        cyc(500);
        frame_clk = 1'b1;
        cyc(1);
        chk("missed pulse", missed, 1);
        frame_clk = 1'b0;
        cyc(1);
        chk("missed one cycle", missed, 0);
        wait_idle("overlap latency", 4299);
        run = 1'b0;
        model_step();
        chk_grid("overlap grid");
        chk("overlap gen +1", generation, 16'(exp_gen));

        // ---- clear vs edit ----
        clear_req = 1'b1;
        edit_we = 1'b1; edit_x = 7'd5; edit_y = 6'd5; edit_val = 1'b1;
        cyc(1);
        clear_req = 1'b0;
        edit_we = 1'b0;
        model_clear();
        chk_grid("idle clear beats edit");
        do_edit(40, 29, 1); mg[40][29] = 1;
        do_edit(40, 30, 1); mg[40][30] = 1;
        do_edit(40, 31, 1); mg[40][31] = 1;
        do_step();
        cyc(50);
        do_edit(20, 20, 1);
        cyc(10);
        do_clear(1'b0);
        cyc(10);
        do_edit(5, 5, 1);
        chk_grid("scan clear held");
        wait_idle("scan clear done", -1);
        model_step();
        model_clear();
        mg[5][5] = 1;
        chk_grid("clear then edit");

        // ---- reset mid-scan ----
        seed_soup(200);
        do_step();
        cyc(1999);
        Reset = 1'b0;
        #1;
        model_clear();
        exp_gen = 0;
        chk_grid("midscan reset grid");
        chk("midscan reset busy", busy, 0);
        chk("midscan reset missed", missed, 0);
        chk("midscan reset gen", generation, 0);
        @(negedge Clk);
        Reset = 1'b1;
        cyc(2);
        chk("post reset idle", busy, 0);
        do_step();
        wait_idle("post reset latency", 4801);
        model_step();
        chk_grid("post reset empty");
        chk("post reset gen", generation, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/life_grid_sequencer.md
# life_grid_sequencer

Owns the 80x60 cell grid displayed by the VGA color mapper and advances it one Conway generation (B3/S23, toroidal) per trigger. Scans every cell once per generation into a shadow buffer and commits it atomically, so the displayed grid never shows a half-updated frame. Also serialises cursor edits and clears from the game logic against the generation scan.

## Interface
- GRID_W, 80, grid columns (x)
- GRID_H, 60, grid rows (y)
- GEN_W, 16, generation counter width
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  vertical-sync level from VGA controller, synchronous to Clk; rising edge is a frame tick
- run  in  1  when high, each frame tick triggers one generation
- step_req  in  1  single-cycle pulse, triggers one generation regardless of run
- clear_req  in  1  single-cycle pulse, zero the grid
- edit_we  in  1  single-cycle cell write strobe
- edit_x  in  7  cell column, 0..GRID_W-1
- edit_y  in  6  cell row, 0..GRID_H-1
- edit_val  in  1  value written to cell
- LOCAL_REG  out  [GRID_W-1:0][GRID_H-1:0]  displayed grid, indexed [x][y]
- busy  out  1  high while a generation is in progress
- missed  out  1  one-cycle pulse when a trigger arrives while busy
- generation  out  GEN_W  completed-generation count

## Operation
- States: IDLE, SCAN, COMMIT.
- Trigger = step_req OR (run AND frame_clk rising edge; previous frame_clk registered, reset 0).
- IDLE: trigger -> SCAN with scan index x=0,y=0. Edits and clears in IDLE apply to LOCAL_REG at that clock edge; clear wins over a same-cycle edit; a same-cycle trigger still starts SCAN, and the scan sees the edited/cleared grid.
- SCAN: one cell per cycle, y inner loop 0..GRID_H-1, x outer 0..GRID_W-1. Next-state of cell (x,y) from LOCAL_REG (never from the shadow): 8 neighbours with wrap, x-1 of 0 is GRID_W-1, y+1 of GRID_H-1 is 0, etc. Live with 2 or 3 neighbours stays live; dead with exactly 3 becomes live; else dead. Result written to shadow[x][y]. After cell (GRID_W-1, GRID_H-1) -> COMMIT.
- COMMIT: LOCAL_REG <= shadow; generation <= generation+1 (wraps modulo 2^GEN_W); then apply pending clear, else pending edit, over the committed grid in the same edge; -> IDLE.
- Edits/clears during SCAN/COMMIT: held in a one-deep pending register (x, y, val, clear flag); a newer edit overwrites an older pending edit; a clear sets the flag and discards any pending edit; an edit after a pending clear is kept and applied after the clear. LOCAL_REG is unchanged by edits during SCAN.
- Triggers during SCAN/COMMIT are dropped and pulse missed the next cycle; no queuing.
- edit_x >= GRID_W or edit_y >= GRID_H: write ignored.
- Reset (any time, incl. mid-scan): LOCAL_REG, shadow, generation all 0; busy 0, missed 0; state IDLE; pending cleared; scan index 0; frame_clk history 0.

## Timing
- busy: high the cycle after a trigger is sampled, through the COMMIT cycle; low in IDLE.
- Generation latency: GRID_W*GRID_H scan cycles + 1 commit = 4801 cycles from SCAN entry to the LOCAL_REG update; at 50 MHz well under one 60 Hz frame.
- LOCAL_REG changes only at: IDLE edit/clear edges, the COMMIT edge, reset.
- IDLE edits visible on LOCAL_REG the cycle after edit_we.
- missed asserts exactly one cycle after the offending trigger.
- Next trigger accepted no earlier than the first IDLE cycle after COMMIT.

## Structure
- Package grid_pkg: GRID_W, GRID_H constants; typedef grid_t = logic [GRID_W-1:0][GRID_H-1:0]; state enum {IDLE, SCAN, COMMIT}; wrap-increment/decrement functions for x and y.
- Sub-module life_cell_rule: combinational, inputs centre bit + 8 neighbour bits, output next-state bit; 4-bit popcount internally.
- Sequencer top holds the FSM, scan counters, shadow buffer, pending-edit register and edge detector.

## Test plan
- Blinker: cells (10,5),(10,6),(10,7) live, step_req -> after 4801 cycles cells (9,6),(10,6),(11,6) live only, generation=1, busy low.
- Wrap glider: glider across corner (79,59)/(0,0), 4 steps -> pattern translated by (+1,+1) mod (80,60), no cells lost.
- Edit during SCAN: edit_we (3,3)=1 at scan cycle 100 -> LOCAL_REG[3][3] unchanged until COMMIT, 1 after COMMIT irrespective of rule.
- Trigger overlap: run=1, frame_clk rising edge mid-scan -> missed pulse one cycle later, generation increments by exactly 1.
- Clear vs edit: clear_req and edit (5,5)=1 in same IDLE cycle -> grid all 0; during SCAN, clear then edit (5,5)=1 -> after COMMIT only (5,5) live.
- Reset mid-scan: Reset low at scan cycle 2000 -> all outputs 0, state IDLE; subsequent step_req on empty grid -> grid stays empty, generation=1.
